// File: rtl/fpu_scvtf_pkg.sv
// Shared constants and state type for the SCVTF/UCVTF integer-to-float converter.
package fpu_scvtf_pkg;

  localparam int unsigned FPU_SP_BIAS   = 127;
  localparam int unsigned FPU_DP_BIAS   = 1023;
  localparam int unsigned FPU_SP_FRAC_W = 23;
  localparam int unsigned FPU_DP_FRAC_W = 52;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_NORM,
    ST_ROUND
  } scvtf_state_t;

endpackage

// File: rtl/fpu_round_pack.sv
// Combinational round-to-nearest-even and IEEE-754 packing of a normalised
// magnitude (mag[63] is the hidden bit, or mag is zero).
module fpu_round_pack
  import fpu_scvtf_pkg::*;
(
  input  logic        sign,
  input  logic [63:0] mag,
  input  logic [6:0]  shcnt,
  input  logic        double,
  output logic [63:0] packed_f,
  output logic        inexact
);

  logic [7:0]  sp_exp;
  logic [10:0] dp_exp;
  logic        sp_g, sp_s, sp_up;
  logic        dp_g, dp_s, dp_up;
  logic [30:0] sp_body;
  logic [62:0] dp_body;

  // Round the fraction; a carry out of the fraction ripples into the exponent.
  always_comb begin
    sp_exp  = 8'(FPU_SP_BIAS + 63) - {1'b0, shcnt};
    dp_exp  = 11'(FPU_DP_BIAS + 63) - {4'b0, shcnt};

    sp_g    = mag[39];
    sp_s    = |mag[38:0];
    sp_up   = sp_g & (sp_s | mag[40]);
    dp_g    = mag[10];
    dp_s    = |mag[9:0];
    dp_up   = dp_g & (dp_s | mag[11]);

    sp_body = {sp_exp, mag[62:40]} + 31'(sp_up);
    dp_body = {dp_exp, mag[62:11]} + 63'(dp_up);

    packed_f = '0;
    inexact  = 1'b0;
    if (mag != '0) begin
      if (double) begin
        packed_f = {sign, dp_body};
        inexact  = dp_g | dp_s;
      end else begin
        packed_f = {32'b0, sign, sp_body};
        inexact  = sp_g | sp_s;
      end
    end
  end

endmodule

// File: rtl/fpu_scvtf.sv
// Iterative 64-bit signed integer to single/double float converter.
// Optional macro FCVT_UNSIGNED_EN adds the is_unsigned input (UCVTF mode).
module fpu_scvtf
  import fpu_scvtf_pkg::*;
#(
  parameter int unsigned SHIFT_STEP = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        double,
  input  logic [63:0] a,
`ifdef FCVT_UNSIGNED_EN
  input  logic        is_unsigned,
`endif
  output logic        busy,
  output logic        done,
  output logic [63:0] result,
  output logic        inexact
);

  scvtf_state_t state_q, state_d;
  logic         sign_q, sign_d;
  logic [63:0]  mag_q, mag_d;
  logic [6:0]   shcnt_q, shcnt_d;
  logic         dbl_q, dbl_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [63:0]  result_q, result_d;
  logic         inexact_q, inexact_d;

  logic         treat_signed;
  logic [63:0]  rp_result;
  logic         rp_inexact;

`ifdef FCVT_UNSIGNED_EN
  assign treat_signed = ~is_unsigned;
`else
  assign treat_signed = 1'b1;
`endif

  fpu_round_pack u_round_pack (
    .sign     (sign_q),
    .mag      (mag_q),
    .shcnt    (shcnt_q),
    .double   (dbl_q),
    .packed_f (rp_result),
    .inexact  (rp_inexact)
  );

  // Next-state: capture operand, normalise by coarse/fine left shifts, then pack.
  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    mag_d     = mag_q;
    shcnt_d   = shcnt_q;
    dbl_d     = dbl_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;
    inexact_d = inexact_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sign_d  = a[63] & treat_signed;
          mag_d   = (a[63] & treat_signed) ? (~a + 64'd1) : a;
          dbl_d   = double;
          shcnt_d = '0;
          busy_d  = 1'b1;
          state_d = (a == '0) ? ST_ROUND : ST_NORM;
        end
      end
      ST_NORM: begin
        if (mag_q[63]) begin
          state_d = ST_ROUND;
        end else if (mag_q[63 -: SHIFT_STEP] == '0) begin
          mag_d   = mag_q << SHIFT_STEP;
          shcnt_d = shcnt_q + 7'(SHIFT_STEP);
        end else begin
          mag_d   = mag_q << 1;
          shcnt_d = shcnt_q + 7'd1;
        end
      end
      ST_ROUND: begin
        result_d  = rp_result;
        inexact_d = rp_inexact;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any conversion in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      sign_q    <= 1'b0;
      mag_q     <= '0;
      shcnt_q   <= '0;
      dbl_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      inexact_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sign_q    <= sign_d;
      mag_q     <= mag_d;
      shcnt_q   <= shcnt_d;
      dbl_q     <= dbl_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      inexact_q <= inexact_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;
  assign inexact = inexact_q;

endmodule

// File: tb/tb_fpu_scvtf.sv
// Self-checking bench for fpu_scvtf: arithmetic reference model plus
// directed vectors with hand-computed results.
module tb_fpu_scvtf;

  localparam int unsigned STEP = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        dbl = 1'b0;
  logic        uns = 1'b0;
  logic [63:0] a = '0;
  logic        busy, done, inexact;
  logic [63:0] result;

  always #5 clk = ~clk;

  fpu_scvtf #(.SHIFT_STEP(STEP)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .double      (dbl),
    .a           (a),
`ifdef FCVT_UNSIGNED_EN
    .is_unsigned (uns),
`endif
    .busy        (busy),
    .done        (done),
    .result      (result),
    .inexact     (inexact)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [63:0] res;
    logic        inx;
    int          done_cyc;
  } exp_t;
  exp_t q[$];
  logic [63:0] last_res = '0;
  logic        last_inx = 1'b0;

  typedef struct {
    logic [63:0] av;
    logic        d;
    logic [63:0] res;
    logic        inx;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: find the leading one, split into kept fraction and discarded
  // remainder, and round by comparing the remainder to half an ulp.
  function automatic logic [64:0] model(input logic [63:0] av, input logic d, input logic u);
    logic        sgn;
    logic [63:0] mag, frac, rem, half, val;
    logic [63:0] res;
    logic        up;
    int          p, fw, bias;
    sgn  = a_is_neg(av, u);
    mag  = sgn ? (64'd0 - av) : av;
    if (mag == '0) return '0;
    fw   = d ? 52 : 23;
    bias = d ? 1023 : 127;
    p = 63;
    while (p > 0 && !mag[p]) p--;
    rem  = '0;
    half = '0;
    if (p <= fw) frac = mag << (fw - p);
    else begin
      frac = mag >> (p - fw);
      rem  = mag & ((64'd1 << (p - fw)) - 64'd1);
      half = 64'd1 << (p - fw - 1);
    end
    frac = frac & ((64'd1 << fw) - 64'd1);
    up   = (p > fw) && ((rem > half) || (rem == half && frac[0]));
    val  = ((64'(bias + p)) << fw) | frac;
    val  = val + 64'(up);
    if (d) res = {sgn, val[62:0]};
    else   res = {32'b0, sgn, val[30:0]};
    return {rem != '0, res};
  endfunction

  function automatic logic a_is_neg(input logic [63:0] av, input logic u);
    return av[63] && !u;
  endfunction

  // Cycles spent normalising: coarse steps cover whole multiples of STEP of
  // leading zeros, single steps the rest, plus the cycle that sees bit 63 set.
  function automatic int nmodel(input logic [63:0] av, input logic u);
    logic [63:0] mag;
    int lz;
    mag = a_is_neg(av, u) ? (64'd0 - av) : av;
    if (mag == '0) return 0;
    lz = 0;
    while (!mag[63 - lz]) lz++;
    return lz / int'(STEP) + lz % int'(STEP) + 1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Compare process: every cycle out of reset, check done/busy/result/inexact.
  always @(negedge clk) begin
    if (reset_n) begin
      if (q.size() > 0 && cyc >= q[0].done_cyc) begin
        check("busy_done_cycle", 64'(busy), 64'd0);
        check("done_pulse", 64'(done), 64'd1);
        check("result", result, q[0].res);
        check("inexact", 64'(inexact), 64'(q[0].inx));
        last_res = q[0].res;
        last_inx = q[0].inx;
        void'(q.pop_front());
      end else begin
        check("busy", 64'(busy), 64'(q.size() > 0));
        check("done_idle", 64'(done), 64'd0);
        check("result_hold", result, last_res);
        check("inexact_hold", 64'(inexact), 64'(last_inx));
      end
    end
  end

  // Drive start for one cycle starting now (caller guarantees DUT idle).
  task automatic issue(input logic [63:0] av, input logic d, input logic u);
    logic [64:0] m;
    exp_t e;
    start = 1'b1;
    a     = av;
    dbl   = d;
    uns   = u;
    @(posedge clk);
    #1;
    start = 1'b0;
    m = model(av, d, u);
    e.res = m[63:0];
    e.inx = m[64];
    e.done_cyc = cyc + nmodel(av, u) + 1;
    q.push_back(e);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && q.size() > 0; i++) begin
      @(posedge clk);
      #1;
    end
    if (q.size() > 0) begin
      check("done_timeout", 64'(q.size()), 64'd0);
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done_cycle();
    for (int i = 0; i < 200 && q.size() > 0 && cyc < q[0].done_cyc; i++) begin
      @(posedge clk);
      #1;
    end
    check("reach_done_cycle", 64'(q.size() > 0 && cyc == q[0].done_cyc), 64'd1);
  endtask

  vec_t vecs[$];
  logic [64:0] m;

  initial begin
    vecs.push_back('{64'd1,                   1'b1, 64'h3FF0000000000000, 1'b0});
    vecs.push_back('{64'hFFFFFFFFFFFFFFFF,    1'b0, 64'h00000000BF800000, 1'b0});
    vecs.push_back('{64'hFFFFFFFFFFFFFFFF,    1'b1, 64'hBFF0000000000000, 1'b0});
    vecs.push_back('{64'd0,                   1'b1, 64'h0000000000000000, 1'b0});
    vecs.push_back('{64'd0,                   1'b0, 64'h0000000000000000, 1'b0});
    vecs.push_back('{64'h0020000000000001,    1'b1, 64'h4340000000000000, 1'b1});
    vecs.push_back('{64'h0020000000000003,    1'b1, 64'h4340000000000002, 1'b1});
    vecs.push_back('{64'h8000000000000000,    1'b1, 64'hC3E0000000000000, 1'b0});
    vecs.push_back('{64'h8000000000000000,    1'b0, 64'h00000000DF000000, 1'b0});
    vecs.push_back('{64'h0000000001000001,    1'b0, 64'h000000004B800000, 1'b1});
    vecs.push_back('{64'h7FFFFFFFFFFFFFFF,    1'b1, 64'h43E0000000000000, 1'b1});
    vecs.push_back('{64'd5,                   1'b0, 64'h0000000040A00000, 1'b0});

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_inexact", 64'(inexact), 64'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency pins for the model
    check("lat_a1", 64'(nmodel(64'd1, 1'b0)), 64'd19);
    check("lat_zero", 64'(nmodel(64'd0, 1'b0)), 64'd0);
    check("lat_min", 64'(nmodel(64'h8000000000000000, 1'b0)), 64'd1);

    // Directed vectors: pin the model against hand values, then run the DUT
    foreach (vecs[i]) begin
      m = model(vecs[i].av, vecs[i].d, 1'b0);
      check($sformatf("model_res_%0d", i), m[63:0], vecs[i].res);
      check($sformatf("model_inx_%0d", i), 64'(m[64]), 64'(vecs[i].inx));
      issue(vecs[i].av, vecs[i].d, 1'b0);
      wait_idle();
    end

`ifdef FCVT_UNSIGNED_EN
    m = model(64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b1);
    check("model_ucvtf", m[63:0], 64'h43F0000000000000);
    issue(64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b1);
    wait_idle();
`endif

    // start while busy must be ignored
    issue(64'h0000000001000001, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b1;
    a     = 64'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();
    repeat (5) @(posedge clk);
    #1;

    // Back-to-back: second start presented in the done cycle
    issue(64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0);
    wait_done_cycle();
    issue(64'h0020000000000003, 1'b1, 1'b0);
    wait_idle();

    // Mid-conversion reset aborts
    issue(64'd1, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_result", result, 64'd0);
    check("abort_inexact", 64'(inexact), 64'd0);
    q.delete();
    last_res = '0;
    last_inx = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    issue(64'd1, 1'b1, 1'b0);
    wait_idle();
    issue(64'h8000000000000000, 1'b0, 1'b0);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
